// File: rtl/fifo_arb_pkg.sv
// Shared constants and width helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

  localparam int ARB_REQ   = 4;
  localparam int ARB_BITS  = 8;
  localparam int ARB_DEPTH = 16;
  localparam int STAT_W    = 16;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping; zero latency.
// When en is low nothing is granted, which is how upstream backpressure reaches requesters.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  localparam int SW = IW + 1;

  logic [SW-1:0] slot;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    for (int off = 0; off < N; off++) begin
      // ptr + off never reaches 2N, so one conditional subtract is a full mod N.
      slot = {1'b0, ptr} + SW'(off);
      if (slot >= SW'(N)) begin
        slot = slot - SW'(N);
      end
      if (en && !found && req[slot[IW-1:0]]) begin
        found                = 1'b1;
        gnt[slot[IW-1:0]]    = 1'b1;
        idx                  = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter in front of fifo_flops; grant-to-push latency 1 cycle, optional stats via FIFO_ARB_STATS_EN.
// Backpressure: credit counter withholds all grants while occ == depth or full is high; requesters hold req until granted.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int requesters = ARB_REQ,
  parameter  int bits       = ARB_BITS,
  parameter  int depth      = ARB_DEPTH,
  localparam int OW         = occ_w(depth),
  localparam int IW         = $clog2(requesters)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [requesters-1:0]        req,
  input  logic [requesters*bits-1:0]   data_in,
  output logic [requesters-1:0]        gnt,
  input  logic                         pop,
  input  logic                         full,
  output logic                         push,
  output logic [bits-1:0]              Din,
  output logic [OW-1:0]                occ,
  output logic                         err,
  output logic [requesters*STAT_W-1:0] grant_cnt
);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            push_q, push_d;
  logic [bits-1:0] din_q, din_d;
  logic            err_q, err_d;

  logic            eligible;
  logic            gnt_any;
  logic            pop_ok;
  logic [IW-1:0]   gnt_idx;

  // A same-cycle pop does not free a credit for this cycle's grant.
  assign eligible = !rst && (occ_q < OW'(depth)) && !full;
  assign gnt_any  = |gnt;
  assign pop_ok   = pop && (occ_q != '0);

  rr_pick #(.N(requesters), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .en  (eligible),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  always_comb begin
    ptr_d  = ptr_q;
    push_d = gnt_any;
    din_d  = din_q;
    occ_d  = occ_q;
    err_d  = err_q;

    if (gnt_any) begin
      ptr_d = (gnt_idx == IW'(requesters - 1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < requesters; i++) begin
      if (gnt[i]) begin
        din_d = data_in[i*bits +: bits];
      end
    end

    case ({gnt_any, pop_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (pop && occ_q == '0) begin
      err_d = 1'b1;
    end
    if (full && occ_q < OW'(depth)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      occ_q  <= '0;
      push_q <= 1'b0;
      din_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      occ_q  <= occ_d;
      push_q <= push_d;
      din_q  <= din_d;
      err_q  <= err_d;
    end
  end

  assign push = push_q;
  assign Din  = din_q;
  assign occ  = occ_q;
  assign err  = err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [requesters];
  logic [STAT_W-1:0] cnt_d [requesters];

  always_comb begin
    for (int i = 0; i < requesters; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < requesters; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < requesters; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
